// File: rtl/hsv_core_pkg.sv
// Shared core types: memory access sizes and the access-split FSM state.
package hsv_core_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE  = 2'd0,
        MEM_SIZE_HALF  = 2'd1,
        MEM_SIZE_WORD  = 2'd2,
        MEM_SIZE_DWORD = 2'd3
    } mem_size_t;

    typedef enum logic {
        SPLIT_IDLE  = 1'b0,
        SPLIT_BEATS = 1'b1
    } split_state_t;

    function automatic logic [3:0] size_bytes(mem_size_t s);
        return 4'd1 << s;
    endfunction

endpackage

// File: rtl/hsv_core_mem_split_lane.sv
// Beat former: aligned address, byte strobe and lane-shifted data
// for either half of a memory access.
module hsv_core_mem_split_lane
    import hsv_core_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    localparam int W  = 8 * WORD_BYTES,
    localparam int OW = $clog2(WORD_BYTES)
) (
    input  logic [W-1:0]          addr,
    input  logic [W-1:0]          wdata,
    input  mem_size_t             size,
    input  logic                  beat1,
    output logic [W-1:0]          beat_address,
    output logic [W-1:0]          beat_wdata,
    output logic [WORD_BYTES-1:0] beat_strobe,
    output logic [OW-1:0]         off,
    output logic                  crossing,
    output logic                  oversize
);

    logic [3:0]              n;
    logic [4:0]              span;
    logic [OW:0]             rem;
    logic [2*WORD_BYTES-1:0] mask;
    logic [2*WORD_BYTES-1:0] sh0;
    logic [2*WORD_BYTES-1:0] sh1;
    logic [W-1:0]            aligned;

    always_comb begin
        off      = addr[OW-1:0];
        n        = size_bytes(size);
        span     = 5'(off) + 5'(n);
        crossing = span > 5'(WORD_BYTES);
        oversize = n > 4'(WORD_BYTES);
        mask     = (2*WORD_BYTES)'((32'd1 << n) - 32'd1);
        rem      = (OW+1)'(WORD_BYTES) - (OW+1)'(off);
        sh0      = mask << off;
        sh1      = mask >> rem;
        aligned  = {addr[W-1:OW], {OW{1'b0}}};
        // Beat 1 carries the bytes that spilled past the first word
        if (beat1) begin
            beat_address = aligned + W'(WORD_BYTES);
            beat_strobe  = sh1[WORD_BYTES-1:0];
            beat_wdata   = wdata >> {rem, 3'b000};
        end else begin
            beat_address = aligned;
            beat_strobe  = sh0[WORD_BYTES-1:0];
            beat_wdata   = wdata << {off, 3'b000};
        end
    end

endmodule

// File: rtl/hsv_core_mem_split.sv
// Splits a load/store into one or two word-aligned bus beats with
// byte strobes, handling word-crossing accesses and pipeline flush.
module hsv_core_mem_split
    import hsv_core_pkg::*;
#(
    parameter int WORD_BYTES       = 4,
    parameter bit ALLOW_MISALIGNED = 1'b1,
    localparam int W  = 8 * WORD_BYTES,
    localparam int OW = $clog2(WORD_BYTES)
) (
    input  logic                  clk_core,
    input  logic                  rst_core,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_base,
    input  logic [W-1:0]          in_offset,
    input  mem_size_t             in_size,
    input  logic                  in_store,
    input  logic [W-1:0]          in_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_address,
    output logic [W-1:0]          out_wdata,
    output logic [WORD_BYTES-1:0] out_strobe,
    output logic                  out_store,
    output logic [OW-1:0]         out_shift,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  out_unaligned
);

    split_state_t state_q, state_d;

    logic                  valid_q, valid_d;
    logic [W-1:0]          address_q, address_d;
    logic [W-1:0]          wdata_q, wdata_d;
    logic [WORD_BYTES-1:0] strobe_q, strobe_d;
    logic                  store_q, store_d;
    logic [OW-1:0]         shift_q, shift_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;
    logic                  unal_q, unal_d;
    logic [W-1:0]          req_addr_q, req_addr_d;
    logic [W-1:0]          req_wdata_q, req_wdata_d;
    mem_size_t             req_size_q, req_size_d;

    logic                  accept;
    logic                  fire;
    logic                  load0;
    logic                  load1;
    logic                  unal;
    logic                  split;
    logic                  lane_beat1;
    logic [W-1:0]          lane_addr;
    logic [W-1:0]          lane_wdata_in;
    mem_size_t             lane_size;
    logic [W-1:0]          lane_address;
    logic [W-1:0]          lane_wdata;
    logic [WORD_BYTES-1:0] lane_strobe;
    logic [OW-1:0]         lane_off;
    logic                  lane_crossing;
    logic                  lane_oversize;

    assign in_ready = (state_q == SPLIT_IDLE)
                    & (~valid_q | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;
    assign fire     = valid_q & out_ready;
    assign load0    = accept;
    assign load1    = (state_q == SPLIT_BEATS) & fire & first_q & ~flush;

    // While splitting, the lane re-forms beat 1 from the captured request
    assign lane_beat1    = (state_q == SPLIT_BEATS);
    assign lane_addr     = lane_beat1 ? req_addr_q : in_base + in_offset;
    assign lane_wdata_in = lane_beat1 ? req_wdata_q : in_wdata;
    assign lane_size     = lane_beat1 ? req_size_q : in_size;

    assign unal  = lane_oversize | (lane_crossing & ~ALLOW_MISALIGNED);
    assign split = lane_crossing & ~unal;

    hsv_core_mem_split_lane #(
        .WORD_BYTES (WORD_BYTES)
    ) u_lane (
        .addr         (lane_addr),
        .wdata        (lane_wdata_in),
        .size         (lane_size),
        .beat1        (lane_beat1),
        .beat_address (lane_address),
        .beat_wdata   (lane_wdata),
        .beat_strobe  (lane_strobe),
        .off          (lane_off),
        .crossing     (lane_crossing),
        .oversize     (lane_oversize)
    );

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state_q <= SPLIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = SPLIT_IDLE;
        end else begin
            case (state_q)
                SPLIT_IDLE: begin
                    if (accept && split) state_d = SPLIT_BEATS;
                end
                SPLIT_BEATS: begin
                    if (fire && !first_q) state_d = SPLIT_IDLE;
                end
                default: state_d = SPLIT_IDLE;
            endcase
        end
    end

    always_comb begin
        valid_d     = valid_q;
        address_d   = address_q;
        wdata_d     = wdata_q;
        strobe_d    = strobe_q;
        store_d     = store_q;
        shift_d     = shift_q;
        first_d     = first_q;
        last_d      = last_q;
        unal_d      = unal_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_size_d  = req_size_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load0) begin
            valid_d     = 1'b1;
            address_d   = lane_address;
            wdata_d     = lane_wdata;
            strobe_d    = unal ? '0 : lane_strobe;
            store_d     = in_store;
            shift_d     = lane_off;
            first_d     = 1'b1;
            last_d      = ~split;
            unal_d      = unal;
            req_addr_d  = lane_addr;
            req_wdata_d = in_wdata;
            req_size_d  = in_size;
        end else if (load1) begin
            valid_d   = 1'b1;
            address_d = lane_address;
            wdata_d   = lane_wdata;
            strobe_d  = lane_strobe;
            first_d   = 1'b0;
            last_d    = 1'b1;
        end else if (fire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            valid_q     <= 1'b0;
            address_q   <= '0;
            wdata_q     <= '0;
            strobe_q    <= '0;
            store_q     <= 1'b0;
            shift_q     <= '0;
            first_q     <= 1'b1;
            last_q      <= 1'b1;
            unal_q      <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_size_q  <= MEM_SIZE_BYTE;
        end else begin
            valid_q     <= valid_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            strobe_q    <= strobe_d;
            store_q     <= store_d;
            shift_q     <= shift_d;
            first_q     <= first_d;
            last_q      <= last_d;
            unal_q      <= unal_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_size_q  <= req_size_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_address   = address_q;
    assign out_wdata     = wdata_q;
    assign out_strobe    = strobe_q;
    assign out_store     = store_q;
    assign out_shift     = shift_q;
    assign out_first     = first_q;
    assign out_last      = last_q;
    assign out_unaligned = unal_q;

endmodule

// File: tb/tb_hsv_core_mem_split.sv
// Directed bench for the access splitter: 32-bit bus with and without
// misaligned support, plus a 64-bit bus instance.
module tb_hsv_core_mem_split;
    import hsv_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_base;
    logic [31:0] in_offset;
    mem_size_t   in_size;
    logic        in_store;
    logic [31:0] in_wdata;
    logic        out_ready;

    logic        a_in_ready, a_valid, a_store, a_first, a_last, a_unal;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_strobe;
    logic [1:0]  a_shift;

    logic        b_in_ready, b_valid, b_store, b_first, b_last, b_unal;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_strobe;
    logic [1:0]  b_shift;

    logic        c_in_valid;
    logic [63:0] c_in_base;
    logic [63:0] c_in_offset;
    mem_size_t   c_in_size;
    logic        c_in_store;
    logic [63:0] c_in_wdata;
    logic        c_out_ready;
    logic        c_in_ready, c_valid, c_store, c_first, c_last, c_unal;
    logic [63:0] c_addr, c_wdata;
    logic [7:0]  c_strobe;
    logic [2:0]  c_shift;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hsv_core_mem_split #(.WORD_BYTES(4), .ALLOW_MISALIGNED(1'b1)) u_a (
        .clk_core(clk), .rst_core(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_base(in_base), .in_offset(in_offset), .in_size(in_size),
        .in_store(in_store), .in_wdata(in_wdata),
        .out_valid(a_valid), .out_ready(out_ready),
        .out_address(a_addr), .out_wdata(a_wdata), .out_strobe(a_strobe),
        .out_store(a_store), .out_shift(a_shift), .out_first(a_first),
        .out_last(a_last), .out_unaligned(a_unal)
    );

    hsv_core_mem_split #(.WORD_BYTES(4), .ALLOW_MISALIGNED(1'b0)) u_b (
        .clk_core(clk), .rst_core(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_base(in_base), .in_offset(in_offset), .in_size(in_size),
        .in_store(in_store), .in_wdata(in_wdata),
        .out_valid(b_valid), .out_ready(out_ready),
        .out_address(b_addr), .out_wdata(b_wdata), .out_strobe(b_strobe),
        .out_store(b_store), .out_shift(b_shift), .out_first(b_first),
        .out_last(b_last), .out_unaligned(b_unal)
    );

    hsv_core_mem_split #(.WORD_BYTES(8), .ALLOW_MISALIGNED(1'b1)) u_c (
        .clk_core(clk), .rst_core(rst), .flush(flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_base(c_in_base), .in_offset(c_in_offset), .in_size(c_in_size),
        .in_store(c_in_store), .in_wdata(c_in_wdata),
        .out_valid(c_valid), .out_ready(c_out_ready),
        .out_address(c_addr), .out_wdata(c_wdata), .out_strobe(c_strobe),
        .out_store(c_store), .out_shift(c_shift), .out_first(c_first),
        .out_last(c_last), .out_unaligned(c_unal)
    );

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(logic [31:0] base, logic [31:0] offs, mem_size_t sz,
                       logic st, logic [31:0] d);
        in_base   = base;
        in_offset = offs;
        in_size   = sz;
        in_store  = st;
        in_wdata  = d;
        in_valid  = 1'b1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_base = '0; in_offset = '0; in_size = MEM_SIZE_BYTE;
        in_store = 1'b0; in_wdata = '0;
        c_in_valid = 1'b0; c_in_base = '0; c_in_offset = '0;
        c_in_size = MEM_SIZE_BYTE; c_in_store = 1'b0; c_in_wdata = '0;
        c_out_ready = 1'b0;
        @(negedge clk);
        tick;
        chk("rst_valid", a_valid, 0);
        chk("rst_first", a_first, 1);
        chk("rst_last", a_last, 1);
        chk("rst_unal", a_unal, 0);
        chk("rst_strobe", a_strobe, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_wdata", a_wdata, 0);
        rst = 1'b0;
        tick;
        chk("idle_ready", a_in_ready, 1);

        // aligned word store
        req(32'h1000, 32'h4, MEM_SIZE_WORD, 1'b1, 32'hAABBCCDD);
        tick;
        in_valid = 1'b0;
        chk("sw_valid", a_valid, 1);
        chk("sw_addr", a_addr, 32'h1004);
        chk("sw_strobe", a_strobe, 4'b1111);
        chk("sw_wdata", a_wdata, 32'hAABBCCDD);
        chk("sw_shift", a_shift, 0);
        chk("sw_first", a_first, 1);
        chk("sw_last", a_last, 1);
        chk("sw_store", a_store, 1);

        // byte store accepted in the same cycle the word beat drains
        req(32'h1003, 32'h0, MEM_SIZE_BYTE, 1'b1, 32'h5A);
        out_ready = 1'b1;
        #1;
        chk("b2b_ready", a_in_ready, 1);
        tick;
        in_valid = 1'b0;
        chk("sb_valid", a_valid, 1);
        chk("sb_addr", a_addr, 32'h1000);
        chk("sb_strobe", a_strobe, 4'b1000);
        chk("sb_wdata", a_wdata, 32'h5A000000);
        chk("sb_shift", a_shift, 3);
        tick;
        chk("sb_drain", a_valid, 0);

        // word store crossing a word boundary
        out_ready = 1'b0;
        req(32'h1000, 32'h2, MEM_SIZE_WORD, 1'b1, 32'h11223344);
        tick;
        in_valid = 1'b0;
        chk("x0_addr", a_addr, 32'h1000);
        chk("x0_strobe", a_strobe, 4'b1100);
        chk("x0_wdata", a_wdata, 32'h33440000);
        chk("x0_first", a_first, 1);
        chk("x0_last", a_last, 0);
        chk("x0_shift", a_shift, 2);
        chk("x0_ready", a_in_ready, 0);
        chk("na_valid", b_valid, 1);
        chk("na_unal", b_unal, 1);
        chk("na_strobe", b_strobe, 4'b0000);
        chk("na_first", b_first, 1);
        chk("na_last", b_last, 1);
        out_ready = 1'b1;
        tick;
        chk("x1_valid", a_valid, 1);
        chk("x1_addr", a_addr, 32'h1004);
        chk("x1_strobe", a_strobe, 4'b0011);
        chk("x1_wdata", a_wdata, 32'h00001122);
        chk("x1_first", a_first, 0);
        chk("x1_last", a_last, 1);
        chk("x1_shift", a_shift, 2);
        chk("x1_ready", a_in_ready, 0);
        chk("na_drain", b_valid, 0);
        tick;
        chk("x_done", a_valid, 0);
        chk("x_ready", a_in_ready, 1);

        // stall on beat 0, then flush drops beat 1
        out_ready = 1'b0;
        req(32'h1000, 32'h2, MEM_SIZE_WORD, 1'b1, 32'h11223344);
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("stall_valid", a_valid, 1);
            chk("stall_addr", a_addr, 32'h1000);
            chk("stall_strobe", a_strobe, 4'b1100);
            chk("stall_wdata", a_wdata, 32'h33440000);
            chk("stall_last", a_last, 0);
        end
        flush = 1'b1;
        #1;
        chk("flush_ready", a_in_ready, 0);
        tick;
        flush = 1'b0;
        #1;
        chk("flush_valid", a_valid, 0);
        chk("flush_idle", a_in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("no_beat1", a_valid, 0);
        end

        // crossing load at the top of the address space
        req(32'hFFFFFFF0, 32'hE, MEM_SIZE_WORD, 1'b0, 32'h0);
        tick;
        in_valid = 1'b0;
        chk("wrap0_addr", a_addr, 32'hFFFFFFFC);
        chk("wrap0_strobe", a_strobe, 4'b1100);
        chk("wrap0_store", a_store, 0);
        tick;
        chk("wrap1_addr", a_addr, 32'h0);
        chk("wrap1_strobe", a_strobe, 4'b0011);
        chk("wrap1_last", a_last, 1);
        tick;
        chk("wrap_done", a_valid, 0);

        // dword on a 4-byte bus cannot be split
        out_ready = 1'b0;
        req(32'h1000, 32'h0, MEM_SIZE_DWORD, 1'b1, 32'h1);
        tick;
        in_valid = 1'b0;
        chk("big_unal", a_unal, 1);
        chk("big_strobe", a_strobe, 4'b0000);
        chk("big_last", a_last, 1);
        chk("big_ready", a_in_ready, 0);
        out_ready = 1'b1;
        tick;
        chk("big_drain", a_valid, 0);

        // reset in the middle of a split
        out_ready = 1'b0;
        req(32'h2000, 32'h3, MEM_SIZE_HALF, 1'b1, 32'hBEEF);
        tick;
        in_valid = 1'b0;
        chk("rs0_last", a_last, 0);
        chk("rs0_strobe", a_strobe, 4'b1000);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rs_valid", a_valid, 0);
        chk("rs_ready", a_in_ready, 1);
        tick;
        chk("rs_no_beat1", a_valid, 0);

        // 64-bit bus dword crossing
        c_in_base   = 64'h0;
        c_in_offset = 64'h6;
        c_in_size   = MEM_SIZE_DWORD;
        c_in_store  = 1'b1;
        c_in_wdata  = 64'h0807060504030201;
        c_in_valid  = 1'b1;
        tick;
        c_in_valid = 1'b0;
        chk("d0_addr", c_addr, 64'h0);
        chk("d0_strobe", c_strobe, 8'hC0);
        chk("d0_wdata", c_wdata, 64'h0201000000000000);
        chk("d0_last", c_last, 0);
        chk("d0_shift", c_shift, 6);
        c_out_ready = 1'b1;
        tick;
        chk("d1_addr", c_addr, 64'h8);
        chk("d1_strobe", c_strobe, 8'h3F);
        chk("d1_wdata", c_wdata, 64'h0000080706050403);
        chk("d1_first", c_first, 0);
        chk("d1_last", c_last, 1);
        chk("d1_shift", c_shift, 6);
        tick;
        chk("d_done", c_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hsv_core_mem_split.md
HSV_CORE_MEM_SPLIT -- requirements
Module: hsv_core_mem_split

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 4, bus word width in bytes; legal values 4 or 8; W = 8*WORD_BYTES.
REQ-002 SHALL have parameter ALLOW_MISALIGNED, default 1; 1 splits word-crossing accesses into two beats, 0 flags them.
REQ-003 SHALL have port clk_core  in  1  core clock; all state on rising edge.
REQ-004 SHALL have port rst_core  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  in  1  pipeline flush; discards the held and pending beats.
REQ-006 SHALL have ports in_valid in 1 / in_ready out 1: request handshake.
REQ-007 SHALL have ports in_base in W, in_offset in W: effective address operands (rs1, immediate).
REQ-008 SHALL have ports in_size in mem_size_t (byte/half/word/dword), in_store in 1, in_wdata in W (datum right-aligned).
REQ-009 SHALL have ports out_valid out 1 / out_ready in 1: beat handshake.
REQ-010 SHALL have ports out_address out W, out_wdata out W, out_strobe out WORD_BYTES, out_store out 1.
REQ-011 SHALL have ports out_shift out $clog2(WORD_BYTES), out_first out 1, out_last out 1, out_unaligned out 1.

Function
REQ-012 SHALL compute addr = in_base + in_offset modulo 2^W; off = addr[$clog2(WORD_BYTES)-1:0]; n = 1 << in_size bytes.
REQ-013 SHALL set in_ready = (state == IDLE) & (~out_valid | out_ready) & ~flush.
REQ-014 SHALL register the first beat on accept (in_valid & in_ready); out_valid rises the next cycle (latency 1).
REQ-015 SHALL hold all out_* stable while out_valid & ~out_ready.
REQ-016 Non-crossing (off + n <= WORD_BYTES): one beat; address = addr with low bits zeroed; strobe = ((1<<n)-1) << off; wdata = in_wdata << 8*off; first = last = 1.
REQ-017 Crossing with ALLOW_MISALIGNED=1: FSM IDLE -> SPLIT; beat0 as REQ-016 with strobe and wdata truncated to WORD_BYTES, first=1, last=0.
REQ-018 In SPLIT, on beat0 handshake SHALL present beat1 next cycle: address = aligned addr + WORD_BYTES (wraps modulo 2^W); strobe = ((1<<n)-1) >> (WORD_BYTES-off); wdata = in_wdata >> 8*(WORD_BYTES-off); first=0, last=1; return to IDLE on beat1 handshake.
REQ-019 Crossing with ALLOW_MISALIGNED=0, or n > WORD_BYTES: one beat, out_unaligned=1, strobe = 0, first = last = 1.
REQ-020 out_shift SHALL equal off on every beat of an access; out_store SHALL equal in_store on every beat.
REQ-021 Reads SHALL use the same strobe computation; downstream ignores strobe for loads.
REQ-022 flush SHALL clear out_valid and force IDLE next cycle, take priority over accept and over out_ready, and drop any unissued beat1.
REQ-023 Back-to-back: when beat handshake and accept occur in the same cycle, the new beat SHALL replace the old with no bubble.

Reset
REQ-024 On rst_core: state=IDLE, out_valid=0, out_first=1, out_last=1, out_unaligned=0, out_strobe=0; data outputs 0.
REQ-025 Reset mid-SPLIT SHALL abandon beat1; in_ready SHALL be 1 the cycle after reset deasserts.

Structure
REQ-026 mem_size_t, MEM_SIZE_* encodings and the split FSM state enum SHALL live in hsv_core_pkg.
REQ-027 Beat formation (strobe/data/address for beat 0 or 1) SHALL be one combinational sub-module, hsv_core_mem_split_lane, instantiated once.

Verification (WORD_BYTES=4 unless stated)
REQ-028 sw base 0x1000 off 0x4 data 0xAABBCCDD -> one beat: addr 0x1004, strobe 1111, wdata 0xAABBCCDD, shift 0, first=last=1.
REQ-029 sb addr 0x1003 data 0x5A -> addr 0x1000, strobe 1000, wdata 0x5A000000, shift 3.
REQ-030 sw addr 0x1002 data 0x11223344, ALLOW=1 -> beat0 0x1000/1100/0x33440000 last=0; beat1 0x1004/0011/0x00001122 last=1; in_ready=0 between beats.
REQ-031 Same access, ALLOW=0 -> single beat, out_unaligned=1, strobe 0000.
REQ-032 out_ready held low 3 cycles on beat0 -> outputs unchanged; then flush asserted -> out_valid=0 next cycle, beat1 never issued, in_ready=1.
REQ-033 lw addr 0xFFFFFFFE -> beat1 addr 0x00000000, strobe 0011; WORD_BYTES=8 sd addr 0x6 data 0x0807060504030201 -> beat0 strobe 0xC0, wdata 0x0201000000000000; beat1 addr 0x8, strobe 0x3F, wdata 0x0000080706050403.
